// File: rtl/cmos_capture_rgb565.sv
// cmos_capture_rgb565: OV5640 DVP capture. The block packs byte pairs into RGB565
// pixels and crops each frame to IMG_HDISP x IMG_VDISP. It drives the SDRAM write
// FIFO, skips the unstable frames that follow enable, and flags malformed lines.
// Ports:
//   cmos_pclk, rst_n          pixel clock, async active-low reset
//   cmos_vsync/href/data      camera DVP bus
//   cap_en                    capture enable (async to pclk)
//   sys_we, sys_data_in       pixel write strobe and RGB565 data
//   frame_valid               high while a captured frame is being written
//   frame_done, line_err      one-cycle status pulses
//   frame_cnt                 captured frame counter (wraps)
module cmos_capture_rgb565 #(
  parameter int unsigned IMG_HDISP  = 1024,
  parameter int unsigned IMG_VDISP  = 720,
  parameter int unsigned FRAME_SKIP = 10,
  parameter int unsigned VSYNC_POL  = 1
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        cap_en,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        line_err,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned XW  = $clog2(IMG_HDISP + 1);
  localparam int unsigned YW  = $clog2(IMG_VDISP + 1);
  localparam int unsigned SKW = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam logic        VPOL = (VSYNC_POL != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOP    = 2'd3   // cap_en dropped: finish the current frame, then idle
  } state_t;

  state_t state_q, state_d;

  logic           cap_s1_q, cap_en_s_q;
  logic           vs1_q, vs2_q, href1_q, href2_q;
  logic [7:0]     data1_q;
  logic           fs_c, href_ok_c, hrise_c, hfall_c, capturing_c;

  logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [7:0]     b0_q, b0_d;
  logic           tog_q, tog_d;
  logic           last_wr_q, last_wr_d;
  logic           sys_we_q, sys_we_d;
  logic [15:0]    sys_data_q, sys_data_d;
  logic           frame_valid_q, frame_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           line_err_q, line_err_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;

  // Input conditioning: cap_en synchronizer and one stage on the DVP bus.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cap_s1_q   <= 1'b0;
      cap_en_s_q <= 1'b0;
      vs1_q      <= 1'b0;
      vs2_q      <= 1'b0;
      href1_q    <= 1'b0;
      href2_q    <= 1'b0;
      data1_q    <= 8'h00;
    end else begin
      cap_s1_q   <= cap_en;
      cap_en_s_q <= cap_s1_q;
      vs1_q      <= VPOL ? cmos_vsync : ~cmos_vsync;
      vs2_q      <= vs1_q;
      href1_q    <= cmos_href;
      href2_q    <= href_ok_c;
      data1_q    <= cmos_data;
    end
  end

  // href during active vsync is masked so it never produces line events.
  assign fs_c        = vs1_q & ~vs2_q;
  assign href_ok_c   = href1_q & ~vs1_q;
  assign hrise_c     = href_ok_c & ~href2_q;
  assign hfall_c     = ~href_ok_c & href2_q;
  assign capturing_c = (state_q == ST_CAPTURE) || (state_q == ST_STOP);

  // State register.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cap_en_s_q) state_d = ST_SKIP;
      ST_SKIP: begin
        if (!cap_en_s_q)                                   state_d = ST_IDLE;
        else if (fs_c && (skip_cnt_q == SKW'(FRAME_SKIP))) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: if (!cap_en_s_q) state_d = ST_STOP;
      ST_STOP:    if (fs_c) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    skip_cnt_d    = skip_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    b0_d          = b0_q;
    tog_d         = tog_q;
    last_wr_d     = 1'b0;
    sys_we_d      = 1'b0;
    sys_data_d    = sys_data_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    line_err_d    = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    // Skipped-frame counter only lives in SKIP.
    if (state_q == ST_SKIP) begin
      if (fs_c) skip_cnt_d = skip_cnt_q + SKW'(1);
    end else begin
      skip_cnt_d = '0;
    end

    if (capturing_c) begin
      if (href_ok_c) begin
        // href rise forces the toggle to "first byte".
        if (hrise_c || !tog_q) begin
          b0_d  = data1_q;
          tog_d = 1'b1;
          if (hrise_c) x_d = '0;
        end else begin
          tog_d = 1'b0;
          if ((x_q < XW'(IMG_HDISP)) && (y_q < YW'(IMG_VDISP))) begin
            sys_we_d   = 1'b1;
            sys_data_d = {b0_q, data1_q};
            last_wr_d  = (x_q == XW'(IMG_HDISP - 1)) && (y_q == YW'(IMG_VDISP - 1));
          end
          if (x_q < XW'(IMG_HDISP)) x_d = x_q + XW'(1);
        end
      end
      if (hfall_c) begin
        if (y_q < YW'(IMG_VDISP)) begin
          line_err_d = tog_q || (x_q < XW'(IMG_HDISP));
          y_d        = y_q + YW'(1);
        end
        tog_d = 1'b0;   // a dangling byte is dropped
      end
      if (fs_c) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
      end
    end else begin
      tog_d = 1'b0;
    end

    if (fs_c) y_d = '0;

    // frame_valid: set by the fs that opens a captured frame, cleared after the last pixel.
    if (last_wr_q) frame_valid_d = 1'b0;
    if (fs_c)      frame_valid_d = (state_d == ST_CAPTURE) || (state_d == ST_STOP);
    if ((state_d == ST_IDLE) || (state_d == ST_SKIP)) frame_valid_d = 1'b0;
  end

  // Datapath and output registers.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      b0_q          <= 8'h00;
      tog_q         <= 1'b0;
      last_wr_q     <= 1'b0;
      sys_we_q      <= 1'b0;
      sys_data_q    <= 16'h0000;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_cnt_q   <= 8'h00;
    end else begin
      skip_cnt_q    <= skip_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      b0_q          <= b0_d;
      tog_q         <= tog_d;
      last_wr_q     <= last_wr_d;
      sys_we_q      <= sys_we_d;
      sys_data_q    <= sys_data_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign sys_we      = sys_we_q;
  assign sys_data_in = sys_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign line_err    = line_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Scoreboard bench for cmos_capture_rgb565 with a 4x2 window and 2 skipped frames.
module tb_cmos_capture_rgb565;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic        cap_en = 1'b0;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        frame_valid;
  logic        frame_done;
  logic        line_err;
  logic [7:0]  frame_cnt;

  cmos_capture_rgb565 #(
    .IMG_HDISP(4), .IMG_VDISP(2), .FRAME_SKIP(2), .VSYNC_POL(1)
  ) dut (
    .cmos_pclk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .cap_en(cap_en), .sys_we(sys_we), .sys_data_in(sys_data_in),
    .frame_valid(frame_valid), .frame_done(frame_done), .line_err(line_err),
    .frame_cnt(frame_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] wr_log[$];
  logic [7:0]  tbl [8];
  int tests = 0, fails = 0, cyc = 0;
  int wr_cnt = 0, err_cnt = 0, done_cnt = 0;
  int exp_err = 0, exp_done = 0, exp_fcnt = 0, drop_at = -1;
  bit fv_chk = 1'b0, use_tbl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] byte_of(input int seed, input int l, input int k);
    if (use_tbl && l == 0 && k < 8) return tbl[k];
    return 8'(seed * 29 + l * 13 + k * 7 + 1);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: pops the scoreboard on every write and tallies status pulses.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (fv_chk) begin
      chk("frame_valid_fall", 32'(frame_valid), 32'd0);
      fv_chk = 1'b0;
    end
    if (rst_n && sys_we) begin
      wr_cnt++;
      wr_log.push_back(sys_data_in);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got data %h, required no write", sys_data_in);
      end else begin
        e = sb.pop_front();
        chk("pixel_data", 32'(sys_data_in), 32'(e.data));
        chk("pixel_latency", 32'(cyc), 32'(e.cyc));
        chk("frame_valid_on_write", 32'(frame_valid), 32'd1);
        if (e.last) fv_chk = 1'b1;
      end
    end
    if (rst_n && line_err)   err_cnt++;
    if (rst_n && frame_done) done_cnt++;
  end

  task automatic send_line(input int l, input int nbytes, input bit cap, input int seed);
    logic [7:0] b, prev;
    exp_t e;
    prev = 8'h00;
    for (int k = 0; k < nbytes; k++) begin
      if (l == 0 && k == drop_at) cap_en = 1'b0;
      b = byte_of(seed, l, k);
      cmos_href = 1'b1;
      cmos_data = b;
      if (cap && (k % 2 == 1) && l < V && (k / 2) < H) begin
        e.data = {prev, b};
        e.cyc  = cyc + 2;
        e.last = ((k / 2) == H - 1) && (l == V - 1);
        sb.push_back(e);
      end
      prev = b;
      @(negedge clk);
    end
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    if (cap && l < V && ((nbytes % 2) != 0 || (nbytes / 2) < H)) exp_err++;
    repeat (3) @(negedge clk);
  endtask

  // One vsync pulse followed by nlines lines; 'done' marks a frame_done at this fs.
  task automatic send_frame(input int nlines, input int nb0, input int nb, input bit cap,
                            input bit done, input int seed);
    if (done) begin
      exp_done++;
      exp_fcnt++;
    end
    cmos_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cmos_vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < nlines; l++) send_line(l, (l == 0) ? nb0 : nb, cap, seed);
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    chk("frame_done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sys_we"},      32'(sys_we),      32'd0);
    chk({tag, "_sys_data_in"}, 32'(sys_data_in), 32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_frame_done"},  32'(frame_done),  32'd0);
    chk({tag, "_line_err"},    32'(line_err),    32'd0);
    chk({tag, "_frame_cnt"},   32'(frame_cnt),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    tbl = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h12, 8'h34, 8'h56, 8'h78};

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // 1: startup skip
    cap_en = 1'b1;
    repeat (6) @(negedge clk);
    w0 = wr_cnt;
    send_frame(2, 8, 8, 1'b0, 1'b0, 1);
    send_frame(2, 8, 8, 1'b0, 1'b0, 2);
    chk("skip_writes", 32'(wr_cnt - w0), 32'd0);
    chk("skip_frame_valid", 32'(frame_valid), 32'd0);
    w0 = wr_cnt;
    send_frame(2, 8, 8, 1'b1, 1'b0, 3);
    chk("first_capture_writes", 32'(wr_cnt - w0), 32'd8);
    send_frame(2, 8, 8, 1'b1, 1'b1, 4);

    // 2: packing of known RGB565 words
    use_tbl = 1'b1;
    wr_log.delete();
    send_frame(2, 8, 8, 1'b1, 1'b1, 5);
    use_tbl = 1'b0;
    chk("pack_log_size", 32'(wr_log.size()), 32'd8);
    if (wr_log.size() >= 2) begin
      chk("pack_word0", 32'(wr_log[0]), 32'h0000F81F);
      chk("pack_word1", 32'(wr_log[1]), 32'h000007E0);
    end

    // 3: cropping, 6-pixel lines x 3 lines
    w0 = wr_cnt;
    send_frame(3, 12, 12, 1'b1, 1'b1, 6);
    chk("crop_writes", 32'(wr_cnt - w0), 32'd8);
    chk("crop_line_err", 32'(err_cnt), 32'(exp_err));

    // 4: malformed 7-byte line
    w0 = wr_cnt;
    send_frame(2, 7, 8, 1'b1, 1'b1, 7);
    chk("malformed_writes", 32'(wr_cnt - w0), 32'd7);
    chk("malformed_line_err", 32'(err_cnt), 32'(exp_err));

    // 5: disable mid-frame after 3 pixels
    w0 = wr_cnt;
    drop_at = 6;
    send_frame(2, 8, 8, 1'b1, 1'b1, 8);
    drop_at = -1;
    chk("disable_frame_writes", 32'(wr_cnt - w0), 32'd8);
    w0 = wr_cnt;
    send_frame(2, 8, 8, 1'b0, 1'b1, 9);
    send_frame(2, 8, 8, 1'b0, 1'b0, 10);
    chk("disabled_writes", 32'(wr_cnt - w0), 32'd0);
    chk("disabled_frame_valid", 32'(frame_valid), 32'd0);

    // 6: async reset mid-line of a captured frame
    cap_en = 1'b1;
    repeat (6) @(negedge clk);
    send_frame(2, 8, 8, 1'b0, 1'b0, 11);
    send_frame(2, 8, 8, 1'b0, 1'b0, 12);
    cmos_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cmos_vsync = 1'b0;
    repeat (3) @(negedge clk);
    cmos_href = 1'b1;
    cmos_data = 8'h5A;
    @(negedge clk);
    chk("pre_reset_frame_valid", 32'(frame_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    exp_fcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    w0 = wr_cnt;
    send_frame(2, 8, 8, 1'b0, 1'b0, 13);
    send_frame(2, 8, 8, 1'b0, 1'b0, 14);
    chk("reskip_writes", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt;
    send_frame(2, 8, 8, 1'b1, 1'b0, 15);
    chk("recapture_writes", 32'(wr_cnt - w0), 32'd8);
    chk("final_line_err", 32'(err_cnt), 32'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
